// File: rtl/wm_panel_ctrl.sv
// Washing-machine front-panel input stage: synchronise/debounce, program settings, session FSM.
// Optional macro WM_PANEL_AUTOLOCK_EN adds lock_req and gates start on the detergent switch.
module wm_panel_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int STOP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       btn_temp,
    input  logic       btn_spin,
    input  logic       btn_mode,
    input  logic       door_sw,
    input  logic       det_sw,
    input  logic       cycle_done,
    output logic       start,
    output logic       stop,
    output logic       pause,
    output logic [1:0] waterTemp,
    output logic [1:0] spinSpeed,
    output logic       dry,
    output logic       washOnly,
    output logic       doorclosed,
    output logic       detergentfilled,
    output logic       reject,
    output logic       busy
`ifdef WM_PANEL_AUTOLOCK_EN
    ,
    output logic       lock_req
`endif
);

    localparam int DCW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES + 1)  : 1;
    localparam int SCW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES + 1) : 1;

    localparam int I_START = 0;
    localparam int I_STOP  = 1;
    localparam int I_PAUSE = 2;
    localparam int I_TEMP  = 3;
    localparam int I_SPIN  = 4;
    localparam int I_MODE  = 5;
    localparam int I_DOOR  = 6;
    localparam int I_DET   = 7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_PAUSE    = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    logic [7:0]     w_raw;
    logic [7:0]     r_sync1;
    logic [7:0]     r_sync2;
    logic [7:0]     r_deb;
    logic [7:0]     r_deb_d;
    logic [DCW-1:0] r_cnt [8];
    logic [5:0]     w_press;
    logic           w_door_fall;
    logic           w_go_ok;
    state_t         r_state;
    state_t         w_next;
    logic           w_reject;
    logic           w_settings_en;
    logic [SCW-1:0] r_stop_cnt;
    logic [1:0]     r_temp;
    logic [1:0]     r_spin;
    logic           r_wash_only;
    logic           r_dry;
    logic           r_start;
    logic           r_stop;
    logic           r_pause;
    logic           r_busy;
    logic           r_reject;

    assign w_raw = {det_sw, door_sw, btn_mode, btn_spin, btn_temp, btn_pause, btn_stop, btn_start};

    // Two-flop synchroniser and per-input stability counter feeding the debounced value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
            r_deb   <= 8'd0;
            r_deb_d <= 8'd0;
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    r_cnt[i] <= '0;
                    r_deb[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + DCW'(1);
                end
            end
        end
    end

    assign w_press     = r_deb[5:0] & ~r_deb_d[5:0];
    assign w_door_fall = r_deb_d[I_DOOR] & ~r_deb[I_DOOR];
`ifdef WM_PANEL_AUTOLOCK_EN
    assign w_go_ok     = r_deb[I_DOOR] & r_deb[I_DET];
`else
    assign w_go_ok     = r_deb[I_DOOR];
`endif

    // Session next-state logic; event priority is stop > done > door-open > start/pause > settings.
    always_comb begin
        w_next        = r_state;
        w_reject      = 1'b0;
        w_settings_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[I_START]) begin
                    if (w_go_ok) w_next = S_RUN;
                    else         w_reject = 1'b1;
                end else begin
                    w_settings_en = 1'b1;
                end
            end
            S_RUN: begin
                if (w_press[I_STOP])       w_next = S_STOPPING;
                else if (cycle_done)       w_next = S_IDLE;
                else if (w_door_fall)      w_next = S_PAUSE;
                else if (w_press[I_PAUSE]) w_next = S_PAUSE;
                else                       w_next = S_RUN;
            end
            S_PAUSE: begin
                if (w_press[I_STOP]) begin
                    w_next = S_STOPPING;
                end else if (w_press[I_PAUSE]) begin
                    if (r_deb[I_DOOR]) w_next = S_RUN;
                    else               w_reject = 1'b1;
                end else begin
                    w_next = S_PAUSE;
                end
            end
            S_STOPPING: begin
                if (r_stop_cnt == SCW'(STOP_CYCLES - 1)) w_next = S_IDLE;
                else                                     w_next = S_STOPPING;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and stop-length counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_stop_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_STOPPING && w_next == S_STOPPING) r_stop_cnt <= r_stop_cnt + SCW'(1);
            else                                               r_stop_cnt <= '0;
        end
    end

    // Program settings, only editable while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_temp      <= 2'd0;
            r_spin      <= 2'd0;
            r_wash_only <= 1'b0;
            r_dry       <= 1'b0;
        end else if (w_settings_en) begin
            if (w_press[I_TEMP]) r_temp <= r_temp + 2'd1;
            if (w_press[I_SPIN]) r_spin <= r_spin + 2'd1;
            if (w_press[I_MODE]) begin
                case ({r_wash_only, r_dry})
                    2'b00:   {r_wash_only, r_dry} <= 2'b10;
                    2'b10:   {r_wash_only, r_dry} <= 2'b01;
                    default: {r_wash_only, r_dry} <= 2'b00;
                endcase
            end
        end
    end

    // Registered controller levels decoded from the current state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_pause  <= 1'b0;
            r_busy   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_start  <= (r_state == S_RUN) || (r_state == S_PAUSE);
            r_stop   <= (r_state == S_STOPPING);
            r_pause  <= (r_state == S_PAUSE);
            r_busy   <= (r_state != S_IDLE);
            r_reject <= w_reject;
        end
    end

    assign start           = r_start;
    assign stop            = r_stop;
    assign pause           = r_pause;
    assign busy            = r_busy;
    assign reject          = r_reject;
    assign waterTemp       = r_temp;
    assign spinSpeed       = r_spin;
    assign washOnly        = r_wash_only;
    assign dry             = r_dry;
    assign doorclosed      = r_deb[I_DOOR];
    assign detergentfilled = r_deb[I_DET];
`ifdef WM_PANEL_AUTOLOCK_EN
    assign lock_req        = r_busy;
`endif

endmodule

// File: doc/wm_panel_ctrl.md
Name: wm_panel_ctrl

Overview:
- Front-panel input stage directly upstream of the washing-machine controller.
- Synchronises and debounces the raw panel buttons and the door/detergent switches.
- Holds the program selection (water temperature, spin speed, wash mode) and runs a session FSM.
- Drives the controller's level inputs: start, stop, pause, waterTemp, spinSpeed, dry, washOnly, doorclosed, detergentfilled.

Parameters:
- DEB_CYCLES, 4, number of consecutive stable synchronised samples required before a debounced input changes (minimum 1).
- STOP_CYCLES, 3, length in cycles of the stop pulse sent to the controller (minimum 1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_start  in  1  raw momentary start button (asynchronous, bouncy).
- btn_stop  in  1  raw momentary stop button.
- btn_pause  in  1  raw momentary pause/resume button.
- btn_temp  in  1  raw button; cycles the water temperature setting.
- btn_spin  in  1  raw button; cycles the spin speed setting.
- btn_mode  in  1  raw button; cycles the wash mode.
- door_sw  in  1  raw door switch; 1 = closed.
- det_sw  in  1  raw detergent switch; 1 = filled.
- cycle_done  in  1  controller "done" feedback.
- start  out  1  level to controller; high while a session is active.
- stop  out  1  stop pulse to controller.
- pause  out  1  level to controller.
- waterTemp  out  2  selected water temperature.
- spinSpeed  out  2  selected spin speed.
- dry  out  1  mode decode: dry-only.
- washOnly  out  1  mode decode: wash-only.
- doorclosed  out  1  debounced door_sw.
- detergentfilled  out  1  debounced det_sw.
- reject  out  1  one-cycle pulse when a start or resume request is refused.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Input conditioning (all 8 raw inputs):
  - 2-flop synchroniser on each input.
  - Per-input stability counter, $clog2(DEB_CYCLES+1) bits wide. It resets to 0 whenever the synchronised value equals the debounced value.
  - The debounced value flips on the edge at which the counter would reach DEB_CYCLES.
  - Debounce reset state: 0 for every input.
  - Press pulse: one cycle, generated on each debounced 0->1 transition of a button; it is combinational from the debounce registers.
- Settings (waterTemp, spinSpeed, mode registers; all reset to 0):
  - Change only in IDLE; presses in any other state are ignored.
  - temp press: waterTemp +1, wrapping 11->00.
  - spin press: spinSpeed +1, wrapping 11->00.
  - mode press: NORMAL(dry=0, washOnly=0) -> WASH_ONLY(washOnly=1) -> DRY(dry=1) -> NORMAL.
  - dry and washOnly are never high together.
- FSM states: IDLE, RUN, PAUSE, STOPPING. Reset state is IDLE.
  - IDLE: start press with doorclosed=1 -> RUN. Start press with doorclosed=0 -> stay in IDLE and pulse reject.
  - RUN: stop press -> STOPPING. cycle_done=1 -> IDLE. Pause press -> PAUSE. doorclosed falling -> PAUSE (forced).
  - PAUSE: stop press -> STOPPING. Pause press with doorclosed=1 -> RUN. Pause press with doorclosed=0 -> stay in PAUSE and pulse reject. cycle_done is ignored.
  - STOPPING: stays for exactly STOP_CYCLES cycles, then -> IDLE. All presses are ignored.
- Output decode (registered, so outputs follow the state with 1 cycle of latency):
  - start = RUN or PAUSE.
  - pause = PAUSE.
  - stop = STOPPING.
  - busy = not IDLE.
- Simultaneous events, in priority order: stop > cycle_done > door-open > start/pause > settings.
  - Start and temp pressed together in IDLE: the FSM moves to RUN and the temp press is dropped.
- Reset values:
  - All outputs 0.
  - Stop-length counter 0.
  - Reset asserted mid-session returns to IDLE with all outputs 0 on the next edge. No stop pulse is issued.
- End-to-end latency: a clean raw press is seen on the state-derived outputs 2 + DEB_CYCLES + 1 edges after it is first sampled.

Optional Feature:
- Macro: WM_PANEL_AUTOLOCK_EN.
- Defined:
  - Adds output lock_req (1 bit), which is high in RUN, PAUSE and STOPPING and drops one cycle after the return to IDLE.
  - In IDLE, a start press with detergentfilled=0 is refused with reject.
- Undefined:
  - No lock_req port.
  - Detergent state does not gate start.

Test Plan (DEB_CYCLES=4, STOP_CYCLES=3):
- Bounce: btn_start toggles every 2 cycles for 20 cycles, then held high with door closed -> exactly one transition to RUN; start=1 at edge 7 after the stable level is first sampled.
- Settings wrap: five temp presses in IDLE -> waterTemp sequence 01,10,11,00,01. Three mode presses -> (washOnly,dry) = 10, 01, 00.
- Door refusal: door_sw=0, press start -> reject pulses once, start stays 0, busy stays 0.
- Pause/resume: in RUN, press pause -> pause=1 and start=1. Open the door, then press pause -> reject. Close the door, then press pause -> pause=0.
- Stop: in RUN, press stop together with cycle_done=1 -> stop high for exactly 3 cycles, then IDLE with start=0. A temp press during STOPPING leaves waterTemp unchanged.
- Reset mid-run: rst_n=0 for 1 cycle while in PAUSE -> all outputs 0 on the next edge and no stop pulse.
